// File: rtl/freq_period_meter.sv
// Measures the period of asynchronous f_in in clk cycles, averaged over 2**AVG_LOG periods.
// Result, valid and timeout are held until the next start request.
module freq_period_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned AVG_LOG     = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_in,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   output logic             timeout,
   output logic [CNT_W-1:0] period
);

   localparam int unsigned ACC_W  = CNT_W + AVG_LOG;
   localparam int unsigned PCNT_W = (AVG_LOG > 0) ? AVG_LOG : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'((1 << AVG_LOG) - 1);
   localparam logic [CNT_W-1:0]  CNT_ONES  = '1;
   // cnt value whose increment would reach all-ones: abort instead of counting further
   localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_ONES - CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t            state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic              edge_q;
   logic              rise_c;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum_c;
   logic [PCNT_W-1:0] pcnt;

   // f_in synchronizer followed by rising-edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], f_in};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign sum_c  = acc + ACC_W'(cnt);

   // measurement FSM; start has priority in every state and masks a same-cycle rise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         valid   <= 1'b0;
         timeout <= 1'b0;
         period  <= '0;
         cnt     <= '0;
         acc     <= '0;
         pcnt    <= '0;
      end else if (start) begin
         state   <= ARM;
         busy    <= 1'b1;
         valid   <= 1'b0;
         timeout <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         pcnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               busy <= 1'b0;
            end
            ARM: begin
               if (rise_c) begin
                  state <= MEASURE;
                  cnt   <= CNT_W'(1);
               end else if (cnt == CNT_PRE) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  valid   <= 1'b1;
                  timeout <= 1'b1;
                  period  <= CNT_ONES;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            MEASURE: begin
               if (rise_c) begin
                  if (pcnt == PCNT_LAST) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     valid  <= 1'b1;
                     period <= CNT_W'(sum_c >> AVG_LOG);
                  end else begin
                     acc  <= sum_c;
                     cnt  <= CNT_W'(1);
                     pcnt <= pcnt + PCNT_W'(1);
                  end
               end else if (cnt == CNT_PRE) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  valid   <= 1'b1;
                  timeout <= 1'b1;
                  period  <= CNT_ONES;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_period_meter.sv
// Bench for freq_period_meter: an averaging instance and a single-period 8-bit instance
// share f_in/start; expected results come from the list of rise-to-rise intervals driven.
module tb_freq_period_meter;

   logic        clk;
   logic        rst;
   logic        f_in;
   logic        start;
   logic        busy_a, valid_a, timeout_a;
   logic [15:0] period_a;
   logic        busy_b, valid_b, timeout_b;
   logic [7:0]  period_b;

   int errors = 0;
   int checks = 0;
   int per_q[$];
   int last_a = 0;

   freq_period_meter #(.CNT_W(16), .AVG_LOG(2), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .f_in(f_in), .start(start),
      .busy(busy_a), .valid(valid_a), .timeout(timeout_a), .period(period_a)
   );

   freq_period_meter #(.CNT_W(8), .AVG_LOG(0), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .f_in(f_in), .start(start),
      .busy(busy_b), .valid(valid_b), .timeout(timeout_b), .period(period_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one f_in rise per entry of per_q, spaced by that entry; optional start pulse
   // 'start_off' cycles into the first high phase. Ends with f_in low just before the next rise.
   task automatic gen_waveform(input int start_off);
      for (int i = 0; i < per_q.size(); i++) begin
         f_in = 1'b1;
         for (int c = 0; c < per_q[i]; c++) begin
            if (c == per_q[i] / 2) f_in = 1'b0;
            start = (i == 0 && c == start_off) ? 1'b1 : 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
   endtask

   task automatic run_meas(input string name, input int lead, input int start_off);
      int skip, exp_a, exp_b, n;
      skip  = (start_off >= 0) ? 1 : 0;
      exp_a = 0;
      for (int k = 0; k < 4; k++) exp_a += per_q[skip + k];
      exp_a = exp_a / 4;
      exp_b = per_q[skip];
      if (start_off < 0) begin
         f_in  = 1'b0;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check({name, "_clr_valid"}, 32'(valid_a), 32'd0);
         check({name, "_clr_busy"},  32'(busy_a),  32'd1);
         check({name, "_held_period"}, 32'(period_a), 32'(last_a));
         repeat (lead) @(negedge clk);
      end
      gen_waveform(start_off);
      check({name, "_pre_busy"},  32'(busy_a),  32'd1);
      check({name, "_pre_valid"}, 32'(valid_a), 32'd0);
      f_in = 1'b1;
      n = 0;
      while (!valid_a && n < 12) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"},    32'(valid_a),   32'd1);
      check({name, "_period"},   32'(period_a),  32'(exp_a));
      check({name, "_timeout"},  32'(timeout_a), 32'd0);
      check({name, "_busy"},     32'(busy_a),    32'd0);
      check({name, "_b_valid"},  32'(valid_b),   32'd1);
      check({name, "_b_period"}, 32'(period_b),  32'(exp_b));
      check({name, "_b_timeout"},32'(timeout_b), 32'd0);
      last_a = exp_a;
      repeat (2) @(negedge clk);
      f_in = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst   = 1'b0;
      f_in  = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",    32'(busy_a),    32'd0);
      check("rst_valid",   32'(valid_a),   32'd0);
      check("rst_timeout", 32'(timeout_a), 32'd0);
      check("rst_period",  32'(period_a),  32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 500 ns f_in period on a 10 ns clock
      per_q = '{50, 50, 50, 50};
      run_meas("p50", 7, -1);

      // 505 ns period: counts alternate 51/50, average truncates
      per_q = '{51, 50, 51, 50};
      run_meas("p505", 9, -1);

      // start coincides with a synced rise: that rise must not open the measurement
      per_q = '{30, 50, 50, 50, 50};
      run_meas("coinc", 0, 2);

      // restart mid-MEASURE
      per_q = '{50, 50};
      f_in  = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      gen_waveform(-1);
      check("mid_valid", 32'(valid_a), 32'd0);
      check("mid_busy",  32'(busy_a),  32'd1);
      per_q = '{50, 50, 50, 50};
      run_meas("restart", 6, -1);

      // randomized periods per interval
      for (int t = 0; t < 10; t++) begin
         per_q = {};
         for (int k = 0; k < 4; k++) per_q.push_back(int'($urandom_range(200, 4)));
         run_meas($sformatf("rnd%0d", t), int'($urandom_range(20, 4)), -1);
      end

      // reset mid-measurement
      per_q = '{40, 40};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      gen_waveform(-1);
      rst = 1'b0;
      #1;
      check("arst_busy",    32'(busy_a),    32'd0);
      check("arst_valid",   32'(valid_a),   32'd0);
      check("arst_period",  32'(period_a),  32'd0);
      check("arst_timeout", 32'(timeout_a), 32'd0);
      check("arst_b_busy",  32'(busy_b),    32'd0);
      check("arst_b_period",32'(period_b),  32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      last_a = 0;
      per_q = '{40, 40, 40, 40, 40, 40};
      gen_waveform(-1);
      check("post_rst_valid", 32'(valid_a), 32'd0);
      check("post_rst_busy",  32'(busy_a),  32'd0);
      check("post_rst_b_valid", 32'(valid_b), 32'd0);
      repeat (4) @(negedge clk);

      // f_in held low: 8-bit instance times out in ARM
      f_in  = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!valid_b && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("to_cycles", 32'((n >= 250 && n <= 260) ? 1 : 0), 32'd1);
      check("to_valid",   32'(valid_b),   32'd1);
      check("to_timeout", 32'(timeout_b), 32'd1);
      check("to_period",  32'(period_b),  32'd255);
      check("to_busy",    32'(busy_b),    32'd0);
      check("to_a_busy",  32'(busy_a),    32'd1);
      check("to_a_timeout", 32'(timeout_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
